// File: rtl/jtcop_vram_arb.sv
// Shares one SDRAM read port among the three BAC06 tilemap VRAM readers, caching one tagged word per reader.
// Define JTCOP_VRAM_RR_EN for round-robin grant; fixed priority b0 > b1 > b2 otherwise.
module jtcop_vram_arb #(
    parameter logic [21:0] B0_OFFSET = 22'h00_0000,
    parameter logic [21:0] B1_OFFSET = 22'h00_2000,
    parameter logic [21:0] B2_OFFSET = 22'h00_2800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        b0_cs,
    input  logic [12:0] b0_addr,
    output logic [15:0] b0_data,
    output logic        b0_ok,
    input  logic        b1_cs,
    input  logic [10:0] b1_addr,
    output logic [15:0] b1_data,
    output logic        b1_ok,
    input  logic        b2_cs,
    input  logic [10:0] b2_addr,
    output logic [15:0] b2_data,
    output logic        b2_ok,
    output logic [21:0] ba_addr,
    output logic        ba_rd,
    input  logic        ba_ack,
    input  logic        ba_rdy,
    input  logic [15:0] data_read
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_ACK = 2'd1;
    localparam logic [1:0] WAIT_RDY = 2'd2;

    logic [1:0]  state;
    logic [2:0]  valid;
    logic [2:0]  pend;
    logic [12:0] tag0;
    logic [10:0] tag1;
    logic [10:0] tag2;
    logic [12:0] gaddr;
    logic [1:0]  gsel;
    logic [1:0]  sel;
    logic [21:0] issue_addr;
    logic [12:0] sel_addr;
    logic        any_pend;
    logic        done;

    assign b0_ok    = b0_cs & valid[0] & (tag0 == b0_addr);
    assign b1_ok    = b1_cs & valid[1] & (tag1 == b1_addr);
    assign b2_ok    = b2_cs & valid[2] & (tag2 == b2_addr);
    assign pend     = {b2_cs & ~b2_ok, b1_cs & ~b1_ok, b0_cs & ~b0_ok};
    assign any_pend = |pend;
    // A simultaneous ack+rdy in WAIT_ACK completes the transaction outright
    assign done     = (state == WAIT_RDY && ba_rdy) || (state == WAIT_ACK && ba_ack && ba_rdy);

`ifdef JTCOP_VRAM_RR_EN
    logic [1:0] last;

    always_comb begin
        sel = 2'd0;
        case (last)
            2'd0:    if (pend[1]) sel = 2'd1; else if (pend[2]) sel = 2'd2; else sel = 2'd0;
            2'd1:    if (pend[2]) sel = 2'd2; else if (pend[0]) sel = 2'd0; else sel = 2'd1;
            default: if (pend[0]) sel = 2'd0; else if (pend[1]) sel = 2'd1; else sel = 2'd2;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last <= 2'd2;
        else if (state == IDLE && any_pend)
            last <= sel;
    end
`else
    always_comb begin
        sel = 2'd2;
        if (pend[0])      sel = 2'd0;
        else if (pend[1]) sel = 2'd1;
    end
`endif

    always_comb begin
        issue_addr = B2_OFFSET + {11'd0, b2_addr};
        sel_addr   = {2'd0, b2_addr};
        if (sel == 2'd0) begin
            issue_addr = B0_OFFSET + {9'd0, b0_addr};
            sel_addr   = b0_addr;
        end else if (sel == 2'd1) begin
            issue_addr = B1_OFFSET + {11'd0, b1_addr};
            sel_addr   = {2'd0, b1_addr};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ba_rd   <= 1'b0;
            ba_addr <= 22'd0;
            gaddr   <= 13'd0;
            gsel    <= 2'd0;
        end else begin
            case (state)
                IDLE: if (any_pend) begin
                    ba_addr <= issue_addr;
                    gaddr   <= sel_addr;
                    gsel    <= sel;
                    ba_rd   <= 1'b1;
                    state   <= WAIT_ACK;
                end
                WAIT_ACK: if (ba_ack) begin
                    ba_rd <= 1'b0;
                    state <= ba_rdy ? IDLE : WAIT_RDY;
                end
                WAIT_RDY: if (ba_rdy) state <= IDLE;
                default: begin
                    ba_rd <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // The word is filed under the issued address, even if the reader moved on meanwhile
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid   <= 3'd0;
            tag0    <= 13'd0;
            tag1    <= 11'd0;
            tag2    <= 11'd0;
            b0_data <= 16'd0;
            b1_data <= 16'd0;
            b2_data <= 16'd0;
        end else if (done) begin
            if (gsel == 2'd0) begin
                b0_data  <= data_read;
                tag0     <= gaddr;
                valid[0] <= 1'b1;
            end else if (gsel == 2'd1) begin
                b1_data  <= data_read;
                tag1     <= gaddr[10:0];
                valid[1] <= 1'b1;
            end else begin
                b2_data  <= data_read;
                tag2     <= gaddr[10:0];
                valid[2] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jtcop_vram_arb.sv
// Self-checking bench for jtcop_vram_arb: table of single reads plus hand-written multi-cycle sequences.
// Expected SDRAM addresses/data go into a scoreboard queue when a request is driven.
module tb_jtcop_vram_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        b0_cs, b1_cs, b2_cs;
    logic [12:0] b0_addr;
    logic [10:0] b1_addr, b2_addr;
    logic [15:0] b0_data, b1_data, b2_data;
    logic        b0_ok, b1_ok, b2_ok;
    logic [21:0] ba_addr;
    logic        ba_rd, ba_ack, ba_rdy;
    logic [15:0] data_read;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int          reader;
        logic [21:0] baAddr;
        logic [15:0] data;
    } sbEntry;
    sbEntry sbQ[$];

    typedef struct {
        int          reader;
        logic [12:0] addr;
        int          ackDelay;
        int          rdyDelay;
        bit          sameCycle;
        logic [15:0] data;
        logic [21:0] expAddr;
    } vecT;
    vecT vecs[6];

    always #5 clk = ~clk;

    jtcop_vram_arb #(.B1_OFFSET(22'h3FFFFF)) dut (
        .clk(clk), .rst_n(rst_n),
        .b0_cs(b0_cs), .b0_addr(b0_addr), .b0_data(b0_data), .b0_ok(b0_ok),
        .b1_cs(b1_cs), .b1_addr(b1_addr), .b1_data(b1_data), .b1_ok(b1_ok),
        .b2_cs(b2_cs), .b2_addr(b2_addr), .b2_data(b2_data), .b2_ok(b2_ok),
        .ba_addr(ba_addr), .ba_rd(ba_rd), .ba_ack(ba_ack), .ba_rdy(ba_rdy),
        .data_read(data_read)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic getOk(input int r);
        return (r == 0) ? b0_ok : (r == 1) ? b1_ok : b2_ok;
    endfunction

    function automatic logic [15:0] getData(input int r);
        return (r == 0) ? b0_data : (r == 1) ? b1_data : b2_data;
    endfunction

    task automatic doReset();
        rst_n = 1'b0;
        b0_cs = 0; b1_cs = 0; b2_cs = 0;
        b0_addr = '0; b1_addr = '0; b2_addr = '0;
        ba_ack = 0; ba_rdy = 0; data_read = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drive one reader alone and record what the SDRAM side should see
    task automatic applyStimulus(input int r, input logic [12:0] a, input logic [21:0] expAddr, input logic [15:0] d);
        b0_cs = 0; b1_cs = 0; b2_cs = 0;
        case (r)
            0:       begin b0_cs = 1; b0_addr = a; end
            1:       begin b1_cs = 1; b1_addr = a[10:0]; end
            default: begin b2_cs = 1; b2_addr = a[10:0]; end
        endcase
        sbQ.push_back('{reader: r, baAddr: expAddr, data: d});
    endtask

    task automatic waitRd(output bit seen);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ba_rd === 1'b1) begin
                seen = 1;
                break;
            end
        end
        if (!seen) checkOutput("rd_timeout", 32'd0, 32'd1);
    endtask

    // Acts as the SDRAM: wait for a request, check it against the scoreboard, ack and return data
    task automatic serve(input int ackDelay, input int rdyDelay, input bit sameCycle, input bit expOk);
        bit     seen;
        sbEntry e;
        waitRd(seen);
        if (sbQ.size() == 0) begin
            checkOutput("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sbQ.pop_front();
        if (!seen) return;
        checkOutput("ba_addr", {10'd0, ba_addr}, {10'd0, e.baAddr});
        for (int i = 0; i < ackDelay; i++) begin
            @(negedge clk);
            checkOutput("rd_hold", {31'd0, ba_rd}, 32'd1);
        end
        ba_ack = 1;
        if (sameCycle) begin
            ba_rdy = 1;
            data_read = e.data;
        end
        @(negedge clk);
        ba_ack = 0;
        ba_rdy = 0;
        checkOutput("rd_drop", {31'd0, ba_rd}, 32'd0);
        if (!sameCycle) begin
            repeat (rdyDelay) @(negedge clk);
            ba_rdy = 1;
            data_read = e.data;
            @(negedge clk);
            ba_rdy = 0;
        end
        checkOutput($sformatf("ok_b%0d", e.reader), {31'd0, getOk(e.reader)}, {31'd0, expOk});
        if (expOk) checkOutput($sformatf("data_b%0d", e.reader), {16'd0, getData(e.reader)}, {16'd0, e.data});
    endtask

    initial begin
        bit seen;
        int rdCount;
        int okLow;

        vecs[0] = '{0, 13'h0010, 1, 2, 1'b0, 16'hA5A5, 22'h000010};
        vecs[1] = '{1, 13'h07FF, 1, 1, 1'b0, 16'h1111, 22'h0007FE};
        vecs[2] = '{2, 13'h0001, 2, 0, 1'b0, 16'h2222, 22'h002801};
        vecs[3] = '{0, 13'h1FFF, 0, 3, 1'b0, 16'hBEEF, 22'h001FFF};
        vecs[4] = '{1, 13'h0000, 0, 0, 1'b0, 16'h3333, 22'h3FFFFF};
        vecs[5] = '{2, 13'h07FF, 1, 0, 1'b1, 16'h4444, 22'h002FFF};

        // Reset values, with a reader already asking
        rst_n = 1'b0;
        b0_cs = 1; b0_addr = '0; b1_cs = 0; b1_addr = '0; b2_cs = 0; b2_addr = '0;
        ba_ack = 0; ba_rdy = 0; data_read = '0;
        @(negedge clk);
        checkOutput("rst_ba_rd", {31'd0, ba_rd}, 32'd0);
        checkOutput("rst_ba_addr", {10'd0, ba_addr}, 32'd0);
        checkOutput("rst_b0_ok", {31'd0, b0_ok}, 32'd0);
        checkOutput("rst_data", {16'd0, b0_data | b1_data | b2_data}, 32'd0);
        doReset();

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].reader, vecs[i].addr, vecs[i].expAddr, vecs[i].data);
            serve(vecs[i].ackDelay, vecs[i].rdyDelay, vecs[i].sameCycle, 1'b1);
        end

        // Held address stays ok without any new SDRAM traffic
        applyStimulus(0, 13'h0010, 22'h000010, 16'hA5A5);
        serve(1, 2, 1'b0, 1'b1);
        rdCount = 0;
        okLow = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ba_rd) rdCount++;
            if (!b0_ok) okLow++;
        end
        checkOutput("hold_no_rd", rdCount, 0);
        checkOutput("hold_ok_low", okLow, 0);

        // All three readers pending; b0 re-pends with a new address after its first grant
        doReset();
        b0_cs = 1; b0_addr = 13'h0100;
        b1_cs = 1; b1_addr = 11'h101;
        b2_cs = 1; b2_addr = 11'h102;
        sbQ.push_back('{reader: 0, baAddr: 22'h000100, data: 16'hC000});
        serve(1, 1, 1'b0, 1'b1);
        b0_addr = 13'h0101;
`ifdef JTCOP_VRAM_RR_EN
        sbQ.push_back('{reader: 1, baAddr: 22'h000100, data: 16'hC101});
        sbQ.push_back('{reader: 2, baAddr: 22'h002902, data: 16'hC202});
        sbQ.push_back('{reader: 0, baAddr: 22'h000101, data: 16'hC001});
`else
        sbQ.push_back('{reader: 0, baAddr: 22'h000101, data: 16'hC001});
        sbQ.push_back('{reader: 1, baAddr: 22'h000100, data: 16'hC101});
        sbQ.push_back('{reader: 2, baAddr: 22'h002902, data: 16'hC202});
`endif
        for (int i = 0; i < 3; i++) serve(1, 1, 1'b0, 1'b1);

        // Address switched while the read is in flight
        b0_addr = 13'h0020;
        waitRd(seen);
        checkOutput("sw_ba_addr", {10'd0, ba_addr}, 32'h000020);
        ba_ack = 1;
        @(negedge clk);
        ba_ack = 0;
        b0_addr = 13'h0021;
        @(negedge clk);
        ba_rdy = 1; data_read = 16'h5555;
        @(negedge clk);
        ba_rdy = 0;
        checkOutput("sw_ok_low", {31'd0, b0_ok}, 32'd0);
        checkOutput("idle_gap", {31'd0, ba_rd}, 32'd0);
        sbQ.push_back('{reader: 0, baAddr: 22'h000021, data: 16'h6666});
        serve(1, 1, 1'b0, 1'b1);

        // Reset while waiting for data
        b0_addr = 13'h0030;
        waitRd(seen);
        ba_ack = 1;
        @(negedge clk);
        ba_ack = 0;
        checkOutput("pre_rst_b1_ok", {31'd0, b1_ok}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_ba_rd", {31'd0, ba_rd}, 32'd0);
        checkOutput("mid_rst_ba_addr", {10'd0, ba_addr}, 32'd0);
        checkOutput("mid_rst_ok", {29'd0, b2_ok, b1_ok, b0_ok}, 32'd0);
        b0_cs = 0; b1_cs = 0; b2_cs = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ba_rdy = 1; data_read = 16'hDEAD;
        @(negedge clk);
        ba_rdy = 0;
        checkOutput("late_rdy_no_rd", {31'd0, ba_rd}, 32'd0);
        b0_cs = 1; b0_addr = 13'h0030;
        #1;
        checkOutput("late_rdy_ok", {31'd0, b0_ok}, 32'd0);
        sbQ.push_back('{reader: 0, baAddr: 22'h000030, data: 16'h7777});
        serve(2, 1, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
